opb_register_bank_ppc2simulink: RTL
===================================

Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single PPC-to-Simulink software register. It presents C_N_REGS writable/readable registers, plus one control/status word, on the OPB slave bus, all in the OPB clock domain. An optional double-buffered mode stages writes in shadow registers and transfers them atomically to the user fabric on a software commit, so multi-word settings change in the same cycle. user_data_out feeds Simulink/yellow-block logic directly.

Parameters:
C_BASEADDR, 32'h01000700, OPB base address; word-aligned.
C_HIGHADDR, 32'h010007FF, top of decoded window; must be at least C_BASEADDR + 4*C_N_REGS + 3.
C_OPB_AWIDTH, 32, OPB address width.
C_OPB_DWIDTH, 32, OPB data width; fixed at 32.
C_N_REGS, 4, number of user registers; legal range 1..16.
C_REG_WIDTH, 32, implemented bits per register, 1..32, LSB-aligned.
C_DOUBLE_BUF, 1, 1 = shadow plus commit; 0 = direct write.
C_FAMILY, "virtex5", target family; no functional effect.

Ports:
OPB_Clk  in  1  sole clock, rising edge.
OPB_Rst  in  1  asynchronous reset, active-low (0 = reset).
OPB_ABus  in  [0:31]  address.
OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7] = register bits 31:24.
OPB_DBus  in  [0:31]  write data; DBus[0] is MSB.
OPB_RNW  in  1  1 = read, 0 = write.
OPB_select  in  1  transfer request.
OPB_seqAddr  in  1  ignored.
Sl_DBus  out  [0:31]  read data.
Sl_errAck  out  1  tied 0.
Sl_retry  out  1  tied 0.
Sl_toutSup  out  1  tied 0.
Sl_xferAck  out  1  transfer acknowledge.
user_data_out  out  C_N_REGS*C_REG_WIDTH  active registers; reg i occupies bits [i*C_REG_WIDTH +: C_REG_WIDTH].
user_update  out  C_N_REGS  one-cycle pulse per register whose active value was loaded.
user_commit  out  1  one-cycle pulse on each commit (double-buffer mode only).

Behaviour:
- Decode: word index w = (ABus - C_BASEADDR) >> 2. Hit when select=1 and C_BASEADDR <= ABus <= C_BASEADDR + 4*C_N_REGS + 3. w < C_N_REGS selects user reg w; w = C_N_REGS selects CTRL. A miss is never acked; the master times out.
- Slave FSM:
  - IDLE: on hit, go to ACK. A write is applied at this edge.
  - ACK: Sl_xferAck=1 for exactly this one cycle; Sl_DBus valid during it. Next state is HOLD.
  - HOLD: Sl_xferAck=0. Return to IDLE when select=0. No second ack while select stays high.
  - Access latency: ack 1 cycle after the first select cycle.
- Sl_DBus is 0 whenever Sl_xferAck=0 (required for OPB OR-bus).
- Reg write: each BE[k]=1 updates its byte. Only bits below C_REG_WIDTH are stored; upper bits are discarded and read back as 0.
  - C_DOUBLE_BUF=1: write goes to shadow[w].
  - C_DOUBLE_BUF=0: write goes to active[w], and user_update[w] pulses on the following cycle.
- Reg read returns shadow[w] (DOUBLE_BUF=1) or active[w] (DOUBLE_BUF=0), zero-extended.
- CTRL write with BE[3]=1 and DBus[31]=1 is a commit:
  - At the next edge, every active[i] <= shadow[i].
  - Simultaneously user_commit=1 and user_update[i]=1 for each i written since the previous commit.
  - The dirty set then clears.
  - With DOUBLE_BUF=0, a commit is a no-op with no pulses.
  - A commit with an empty dirty set still pulses user_commit, with user_update all 0.
- CTRL read: bit 0 (DBus[31]) = dirty-set non-empty; bits 15:8 = C_N_REGS; bits 23:16 = C_REG_WIDTH; all other bits 0.
- Rewriting the same register before a commit overwrites the shadow; it still counts once in the dirty set.
- Reset (OPB_Rst=0, asynchronous):
  - Shadow, active, dirty, user_update, user_commit, Sl_xferAck and Sl_DBus all go to 0 immediately; FSM goes to IDLE.
  - A transfer in flight at reset is dropped, not acked.
  - Leaving reset with select still high: an access is acked only if select is seen in IDLE, which it is.

Test Plan:
- Reset, then read reg0..3 and CTRL -> reads 0; CTRL = 32'h0020_0400 (C_N_REGS=4, C_REG_WIDTH=32); all user outputs 0.
- DOUBLE_BUF=1: write reg1=32'hDEADBEEF, BE=4'b1111 -> ack 1 cycle later, width 1; readback DEADBEEF; user_data_out unchanged; CTRL bit0=1.
- Write reg0=1 and reg2=2, then CTRL=1 -> one cycle after the commit edge user_data_out reg0=1, reg2=2; user_commit=1; user_update=4'b0101; CTRL bit0=0.
- Byte-enable write to reg3 of DBus=32'h11223344 with BE=4'b0101 onto existing 0 -> reg3 reads 32'h00220044.
- C_REG_WIDTH=8: write 32'hFFFFFFA5 -> read 32'h000000A5; with DOUBLE_BUF=0, user_update pulses once with no commit needed.
- Hold select high for 5 cycles -> exactly one ack. Access to address base+0x14 with N=4 -> no ack. Assert reset during the ACK cycle -> ack drops in the same cycle and registers read 0.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for the PPC-to-Simulink register bank.
// Bit 0 is the MSB on every vector, matching OPB numbering.
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus,
    output OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry,
    input  Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus,
    input  OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry,
    output Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB register bank feeding Simulink fabric, with optional
// shadow registers committed atomically through a CTRL word.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01000700,
  parameter logic [31:0] C_HIGHADDR   = 32'h010007FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_N_REGS     = 4,
  parameter int          C_REG_WIDTH  = 32,
  parameter int          C_DOUBLE_BUF = 1,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic OPB_Clk,
  input  logic OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [C_N_REGS*C_REG_WIDTH-1:0] user_data_out,
  output logic [C_N_REGS-1:0] user_update,
  output logic user_commit
);

  localparam logic [31:0] LAST =
    C_BASEADDR + 32'(4 * C_N_REGS + 3);

  if (C_N_REGS < 1 || C_N_REGS > 16 ||
      C_REG_WIDTH < 1 || C_REG_WIDTH > 32 ||
      C_OPB_DWIDTH != 32 || C_OPB_AWIDTH != 32 ||
      C_FAMILY == "") begin : g_bad_cfg
    $error("opb_register_bank: illegal parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_HOLD
  } state_t;

  state_t state;

  logic [C_REG_WIDTH-1:0] shadow [C_N_REGS];
  logic [C_REG_WIDTH-1:0] active [C_N_REGS];
  logic [C_N_REGS-1:0]    dirty;
  logic                   xfer_ack;
  logic [31:0]            sl_dbus;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] offset;
  logic [29:0] wrd;
  logic        hit;
  logic        ctrl_sel;
  logic        commit_req;
  logic [C_N_REGS-1:0] reg_sel;
  logic [31:0] rd_reg;
  logic [31:0] merged;
  logic [31:0] ctrl_word;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign addr   = opb.OPB_ABus;
  assign wdata  = opb.OPB_DBus;
  assign be     = opb.OPB_BE;
  assign offset = addr - C_BASEADDR;
  assign wrd    = offset[31:2];

  assign hit = opb.OPB_select &&
               addr >= C_BASEADDR &&
               addr <= LAST &&
               addr <= C_HIGHADDR;

  assign ctrl_sel = (wrd == 30'(C_N_REGS));

  assign commit_req = ctrl_sel && !opb.OPB_RNW &&
                      be[0] && wdata[0];

  assign unused_bits = ^{opb.OPB_seqAddr, offset[1:0]};

  // Decode the word index and fetch the addressed register.
  always_comb begin
    reg_sel = '0;
    rd_reg  = '0;
    for (int i = 0; i < C_N_REGS; i++) begin
      if (wrd == 30'(i)) begin
        reg_sel[i] = 1'b1;
        rd_reg = (C_DOUBLE_BUF != 0) ?
                 32'(shadow[i]) : 32'(active[i]);
      end
    end
  end

  // Byte-lane merge of write data onto the current value.
  always_comb begin
    merged = '0;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = be[k] ?
                         wdata[8*k +: 8] : rd_reg[8*k +: 8];
    end
  end

  assign ctrl_word = {8'd0, 8'(C_REG_WIDTH),
                      8'(C_N_REGS), 7'd0, |dirty};

  assign rd_data = ctrl_sel ? ctrl_word : rd_reg;

  // Slave handshake, register writes and commit transfer.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state       <= S_IDLE;
      xfer_ack    <= 1'b0;
      sl_dbus     <= '0;
      dirty       <= '0;
      user_update <= '0;
      user_commit <= 1'b0;
      for (int i = 0; i < C_N_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      user_update <= '0;
      user_commit <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (hit) begin
            state    <= S_ACK;
            xfer_ack <= 1'b1;
            sl_dbus  <= opb.OPB_RNW ? rd_data : 32'd0;
            if (!opb.OPB_RNW) begin
              for (int i = 0; i < C_N_REGS; i++) begin
                if (reg_sel[i]) begin
                  if (C_DOUBLE_BUF != 0) begin
                    shadow[i] <= merged[C_REG_WIDTH-1:0];
                    dirty[i]  <= 1'b1;
                  end else begin
                    active[i]      <= merged[C_REG_WIDTH-1:0];
                    user_update[i] <= 1'b1;
                  end
                end
              end
              if (commit_req && C_DOUBLE_BUF != 0) begin
                for (int i = 0; i < C_N_REGS; i++) begin
                  active[i] <= shadow[i];
                end
                user_update <= dirty;
                user_commit <= 1'b1;
                dirty       <= '0;
              end
            end
          end
        end
        S_ACK: begin
          state    <= S_HOLD;
          xfer_ack <= 1'b0;
          sl_dbus  <= '0;
        end
        S_HOLD: begin
          if (!opb.OPB_select) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < C_N_REGS; i++) begin : g_out
    assign user_data_out[i*C_REG_WIDTH +: C_REG_WIDTH] =
      active[i];
  end

  assign opb.Sl_DBus    = sl_dbus;
  assign opb.Sl_xferAck = xfer_ack;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule
